// File: rtl/receive_instr_if.sv
// ----------------------------------------------------------------------------
// receive_instr_if
// Bundles the transmitter handshake, the buffer read port and the load status
// of receive_instr.
//   slave  : receive_instr side (drives syn, read data and status)
//   master : transmitter / host side (drives start, instr, ack, last, raddr)
// Signals:
//   r_i_start  load request            r_o_syn    one-cycle request for a word
//   r_i_instr  instruction word        r_i_ack    r_i_instr is valid
//   r_i_last   final word of stream    r_i_raddr  buffer read address
//   r_o_rdata  registered read data    r_o_busy   load in progress
//   r_o_done   load ended on last      r_o_err    load aborted
//   r_o_count  words stored by current/last load
// ----------------------------------------------------------------------------
interface receive_instr_if #(
  parameter int IWIDTH = 32,
  parameter int AWIDTH = 6
);
  logic              r_i_start;
  logic              r_o_syn;
  logic [IWIDTH-1:0] r_i_instr;
  logic              r_i_ack;
  logic              r_i_last;
  logic [AWIDTH-1:0] r_i_raddr;
  logic [IWIDTH-1:0] r_o_rdata;
  logic              r_o_busy;
  logic              r_o_done;
  logic              r_o_err;
  logic [AWIDTH-1:0] r_o_count;

  modport slave (
    input  r_i_start, r_i_instr, r_i_ack, r_i_last, r_i_raddr,
    output r_o_syn, r_o_rdata, r_o_busy, r_o_done, r_o_err, r_o_count
  );

  modport master (
    output r_i_start, r_i_instr, r_i_ack, r_i_last, r_i_raddr,
    input  r_o_syn, r_o_rdata, r_o_busy, r_o_done, r_o_err, r_o_count
  );
endinterface

// File: rtl/receive_instr.sv
// ----------------------------------------------------------------------------
// receive_instr
// Pulls an instruction stream word by word from a transmitter into a local
// buffer. Each word is requested with a one-cycle syn pulse and accepted on
// ack; the load ends on last (done), on an ack timeout or on buffer overflow
// (err). The buffer is readable at any time through a registered read port.
// Ports:
//   r_clk  clock (rising edge)
//   r_rst  asynchronous active-low reset
//   bus    receive_instr_if.slave (handshake, read port, status)
// ----------------------------------------------------------------------------
module receive_instr #(
  parameter int IWIDTH  = 32,
  parameter int DEPTH   = 36,
  parameter int AWIDTH  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic          r_clk,
  input  logic          r_rst,
  receive_instr_if.slave bus
);

  localparam int TWIDTH = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_END
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [AWIDTH-1:0] r_count, w_count_nxt;
  logic [TWIDTH-1:0] r_timer, w_timer_nxt;
  logic              r_done,  w_done_nxt;
  logic              r_err,   w_err_nxt;
  logic              w_we;
  logic [IWIDTH-1:0] r_mem [DEPTH];
  logic [IWIDTH-1:0] r_rdata;

  // Next-state and datapath control.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_timer_nxt = r_timer;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_we        = 1'b0;

    unique case (r_state)
      // done/err persist in END until the next start clears them.
      S_IDLE, S_END: begin
        if (bus.r_i_start) begin
          w_state_nxt = S_REQ;
          w_count_nxt = '0;
          w_done_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
        end
      end

      S_REQ: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (bus.r_i_ack) begin
          if (r_count == AWIDTH'(DEPTH)) begin
            // Buffer full: there is no slot for this word, drop it.
            w_state_nxt = S_END;
            w_err_nxt   = 1'b1;
          end else begin
            w_we        = 1'b1;
            w_count_nxt = r_count + 1'b1;
            if (bus.r_i_last) begin
              w_state_nxt = S_END;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_REQ;
            end
          end
        end else begin
          // Timer counts ack-less WAIT cycles; the TIMEOUT-th one aborts.
          w_timer_nxt = r_timer + 1'b1;
          if (w_timer_nxt == TWIDTH'(TIMEOUT)) begin
            w_state_nxt = S_END;
            w_err_nxt   = 1'b1;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_timer <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_timer <= w_timer_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // NOTE: the buffer has no reset so it maps onto plain RAM; its contents
  // also survive resets and later loads, which the host may rely on.
  always_ff @(posedge r_clk) begin
    if (w_we) begin
      r_mem[r_count] <= bus.r_i_instr;
    end
  end

  // Registered read; a same-edge write is not yet visible, so old data wins.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      r_rdata <= '0;
    end else if (bus.r_i_raddr < AWIDTH'(DEPTH)) begin
      r_rdata <= r_mem[bus.r_i_raddr];
    end else begin
      r_rdata <= '0;
    end
  end

  assign bus.r_o_syn   = (r_state == S_REQ);
  assign bus.r_o_busy  = (r_state == S_REQ) || (r_state == S_WAIT);
  assign bus.r_o_done  = r_done;
  assign bus.r_o_err   = r_err;
  assign bus.r_o_count = r_count;
  assign bus.r_o_rdata = r_rdata;

endmodule
